// File: rtl/transmisor_sincronizador_pkg.sv
// Shared definitions for the 8b/10b serial transmitter: code tables,
// legal control-code list, width-select modes and symbol length.
package transmisor_sincronizador_pkg;

  localparam int SYM_LEN = 10;

  localparam logic [1:0] MODE_8  = 2'b00;
  localparam logic [1:0] MODE_16 = 2'b01;
  localparam logic [1:0] MODE_32 = 2'b10;

  typedef enum logic {
    ST_LOAD,
    ST_SEND
  } tx_state_t;

  // 5b/6b code for EDCBA, written as abcdei in its RD- form.
  function automatic logic [5:0] enc_5b6b(input logic [4:0] x);
    logic [5:0] c;
    c = 6'b000000;
    case (x)
      5'd0:  c = 6'b100111;
      5'd1:  c = 6'b011101;
      5'd2:  c = 6'b101101;
      5'd3:  c = 6'b110001;
      5'd4:  c = 6'b110101;
      5'd5:  c = 6'b101001;
      5'd6:  c = 6'b011001;
      5'd7:  c = 6'b111000;
      5'd8:  c = 6'b111001;
      5'd9:  c = 6'b100101;
      5'd10: c = 6'b010101;
      5'd11: c = 6'b110100;
      5'd12: c = 6'b001101;
      5'd13: c = 6'b101100;
      5'd14: c = 6'b011100;
      5'd15: c = 6'b010111;
      5'd16: c = 6'b011011;
      5'd17: c = 6'b100011;
      5'd18: c = 6'b010011;
      5'd19: c = 6'b110010;
      5'd20: c = 6'b001011;
      5'd21: c = 6'b101010;
      5'd22: c = 6'b011010;
      5'd23: c = 6'b111010;
      5'd24: c = 6'b110011;
      5'd25: c = 6'b100110;
      5'd26: c = 6'b010110;
      5'd27: c = 6'b110110;
      5'd28: c = 6'b001110;
      5'd29: c = 6'b101110;
      5'd30: c = 6'b011110;
      5'd31: c = 6'b101011;
      default: c = 6'b000000;
    endcase
    return c;
  endfunction

  // 3b/4b code for HGF, written as fghj in its RD- form (primary D.x.7).
  function automatic logic [3:0] enc_3b4b(input logic [2:0] y);
    logic [3:0] c;
    c = 4'b0000;
    case (y)
      3'd0: c = 4'b1011;
      3'd1: c = 4'b1001;
      3'd2: c = 4'b0101;
      3'd3: c = 4'b1100;
      3'd4: c = 4'b1101;
      3'd5: c = 4'b1010;
      3'd6: c = 4'b0110;
      3'd7: c = 4'b1110;
      default: c = 4'b0000;
    endcase
    return c;
  endfunction

  // Legal control codes: K28.0-K28.7, K23.7, K27.7, K29.7, K30.7.
  function automatic logic is_legal_k(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    case (b)
      8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
      8'hF7, 8'hFB, 8'hFD, 8'hFE: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Full 10-bit control symbol (abcdeifghj) in RD- form; RD+ is its complement.
  function automatic logic [9:0] k_code_neg(input logic [7:0] b);
    logic [9:0] c;
    c = 10'b0;
    case (b)
      8'h1C: c = 10'b0011110100;
      8'h3C: c = 10'b0011111001;
      8'h5C: c = 10'b0011110101;
      8'h7C: c = 10'b0011110011;
      8'h9C: c = 10'b0011110010;
      8'hBC: c = 10'b0011111010;
      8'hDC: c = 10'b0011110110;
      8'hFC: c = 10'b0011111000;
      8'hF7: c = 10'b1110101000;
      8'hFB: c = 10'b1101101000;
      8'hFD: c = 10'b1011101000;
      8'hFE: c = 10'b0111101000;
      default: c = 10'b0;
    endcase
    return c;
  endfunction

  // Index of the last byte of a word for a given width select (11 acts as 8-bit).
  function automatic logic [1:0] last_byte_idx(input logic [1:0] mode);
    logic [1:0] r;
    r = 2'd0;
    case (mode)
      MODE_16: r = 2'd1;
      MODE_32: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/transmisor_sincronizador_encoder.sv
// Combinational 8b/10b encoder: byte + K flag + running disparity in,
// symbol (abcdeifghj, a in bit 9), next disparity and illegal-K flag out.
// rd = 0 means negative running disparity.
module encoder_8b10b
  import transmisor_sincronizador_pkg::*;
(
  input  logic [7:0] data,
  input  logic       k,
  input  logic       rd,
  output logic [9:0] symbol,
  output logic       rd_next,
  output logic       invalid
);

  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] code6;
  logic [3:0] code4;
  logic [9:0] k_sym;
  logic       rd_mid;
  logic       use_alt;
  logic       k_legal;

  // Data path uses 5b/6b then 3b/4b with disparity tracked between the halves;
  // legal control bytes bypass it with a whole-symbol table.
  always_comb begin
    x       = data[4:0];
    y       = data[7:5];
    k_legal = is_legal_k(data);

    code6 = enc_5b6b(x);
    if (rd && (($countones(code6) != 3) || (x == 5'd7)))
      code6 = ~code6;
    rd_mid = rd ^ ($countones(code6) != 3);

    // D.x.A7 avoids a run of five equal bits across the 6b/4b seam.
    use_alt = (y == 3'd7) &&
              ((!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
               ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
    code4 = use_alt ? 4'b0111 : enc_3b4b(y);
    if (rd_mid && (($countones(code4) != 2) || (y == 3'd3)))
      code4 = ~code4;

    k_sym = k_code_neg(data);
    if (rd)
      k_sym = ~k_sym;

    symbol  = {code6, code4};
    rd_next = rd_mid ^ ($countones(code4) != 2);
    invalid = 1'b0;
    if (k && k_legal) begin
      symbol  = k_sym;
      rd_next = rd ^ ($countones(k_sym) != 5);
    end else if (k) begin
      invalid = 1'b1;
    end
  end

endmodule

// File: rtl/transmisor_sincronizador.sv
// 8b/10b serial transmitter: captures an 8/16/32-bit word at each word
// boundary, encodes it byte by byte (LSB byte first), serializes each
// symbol bit a..j and passes the stream through a 2-flop synchronizer.
module transmisor_sincronizador
  import transmisor_sincronizador_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enb,
  input  logic        K,
  input  logic [7:0]  dataIn,
  input  logic [15:0] dataIn16,
  input  logic [31:0] dataIn32,
  input  logic [1:0]  dataS,
  input  logic        TxElecIdle,
  output logic        serialOut,
  output logic        dataSync,
  output logic        invalid_value
);

  tx_state_t   state, state_next;
  logic        capture, send;
  logic [31:0] word_reg, word_sel;
  logic [1:0]  mode_reg;
  logic        k_reg;
  logic [3:0]  bit_cnt, bit_pos;
  logic [1:0]  byte_idx;
  logic        rd;
  logic        serial_q, invalid_q;
  logic        sync1, sync2;
  logic [7:0]  cur_byte;
  logic [9:0]  symbol;
  logic        rd_next, sym_invalid;
  logic        sym_last, byte_last;

  assign cur_byte  = word_reg[{byte_idx, 3'b000} +: 8];
  assign bit_pos   = 4'(SYM_LEN - 1) - bit_cnt;
  assign sym_last  = (bit_cnt == 4'(SYM_LEN - 1));
  assign byte_last = (byte_idx == last_byte_idx(mode_reg));

  encoder_8b10b u_encoder (
    .data    (cur_byte),
    .k       (k_reg),
    .rd      (rd),
    .symbol  (symbol),
    .rd_next (rd_next),
    .invalid (sym_invalid)
  );

  // Word select: 11 falls back to byte mode.
  always_comb begin
    word_sel = {24'b0, dataIn};
    case (dataS)
      MODE_16: word_sel = {16'b0, dataIn16};
      MODE_32: word_sel = dataIn32;
      default: word_sel = {24'b0, dataIn};
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= ST_LOAD;
    else if (enb)
      state <= state_next;
  end

  // Next state: LOAD captures a fresh word, SEND re-captures on the last bit of the last byte.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    send       = 1'b0;
    if (TxElecIdle) begin
      state_next = ST_LOAD;
    end else begin
      case (state)
        ST_LOAD: begin
          capture    = 1'b1;
          state_next = ST_SEND;
        end
        ST_SEND: begin
          send    = 1'b1;
          capture = sym_last && byte_last;
        end
        default: state_next = ST_LOAD;
      endcase
    end
  end

  // Captured word, width and K flag; only meaningful once the sequencer has loaded them.
  always_ff @(posedge clk) begin
    if (enb && capture) begin
      word_reg <= word_sel;
      mode_reg <= dataS;
      k_reg    <= K;
    end
  end

  // Bit/byte counters, running disparity and the serial/invalid output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt   <= 4'd0;
      byte_idx  <= 2'd0;
      rd        <= 1'b0;
      serial_q  <= 1'b0;
      invalid_q <= 1'b0;
    end else if (enb) begin
      if (!send) begin
        bit_cnt   <= 4'd0;
        byte_idx  <= 2'd0;
        serial_q  <= 1'b0;
        invalid_q <= 1'b0;
      end else begin
        serial_q  <= symbol[bit_pos];
        invalid_q <= sym_invalid;
        if (sym_last) begin
          rd       <= rd_next;
          bit_cnt  <= 4'd0;
          byte_idx <= byte_last ? 2'd0 : byte_idx + 2'd1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

  // Two-flop synchronizer on the serial stream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else if (enb) begin
      sync1 <= serial_q;
      sync2 <= sync1;
    end
  end

  assign serialOut     = serial_q;
  assign invalid_value = invalid_q;
  assign dataSync      = sync2;

endmodule

// File: tb/tb_transmisor_sincronizador.sv
module tb_transmisor_sincronizador;

  logic        clk = 1'b0;
  logic        rst, enb, K, TxElecIdle;
  logic [7:0]  dataIn;
  logic [15:0] dataIn16;
  logic [31:0] dataIn32;
  logic [1:0]  dataS;
  logic        serialOut, dataSync, invalid_value;

  int   checks = 0;
  int   failures = 0;
  logic p1, p2, ds_prev;

  always #5 clk = ~clk;

  transmisor_sincronizador dut (
    .clk           (clk),
    .rst           (rst),
    .enb           (enb),
    .K             (K),
    .dataIn        (dataIn),
    .dataIn16      (dataIn16),
    .dataIn32      (dataIn32),
    .dataS         (dataS),
    .TxElecIdle    (TxElecIdle),
    .serialOut     (serialOut),
    .dataSync      (dataSync),
    .invalid_value (invalid_value)
  );

  typedef struct {
    logic [1:0]  ds;
    logic        k;
    logic [31:0] word;
    int          nsym;
    logic [39:0] syms;
    logic [3:0]  invs;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic step(input logic es, input logic ei, input string tag);
    @(negedge clk);
    chk({tag, " serialOut"}, serialOut, es);
    chk({tag, " invalid_value"}, invalid_value, ei);
    chk({tag, " dataSync"}, dataSync, p2);
    ds_prev = p2;
    p2 = p1;
    p1 = es;
  endtask

  task automatic freeze_step(input logic es, input string tag);
    @(negedge clk);
    chk({tag, " serialOut"}, serialOut, es);
    chk({tag, " dataSync"}, dataSync, ds_prev);
  endtask

  task automatic send_bits(input logic [9:0] sym, input int first, input int last,
                           input logic inv, input string tag);
    for (int b = first; b <= last; b++)
      step(sym[9 - b], inv, $sformatf("%s b%0d", tag, b));
  endtask

  task automatic scramble_data();
    logic [31:0] r;
    r = $urandom;
    dataIn   = r[7:0];
    dataIn16 = r[23:8];
    r = $urandom;
    dataIn32 = r;
    dataS    = r[1:0] ^ r[9:8];
    K        = r[4];
  endtask

  task automatic apply_vec(input vec_t vv);
    scramble_data();
    dataS = vv.ds;
    K     = vv.k;
    case (vv.ds)
      2'b01:   dataIn16 = vv.word[15:0];
      2'b10:   dataIn32 = vv.word;
      default: dataIn   = vv.word[7:0];
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("reset serialOut", serialOut, 1'b0);
    chk("reset dataSync", dataSync, 1'b0);
    chk("reset invalid_value", invalid_value, 1'b0);
    p1 = 1'b0;
    p2 = 1'b0;
    ds_prev = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [9:0]  sym;

    vecs[0] = '{ds: 2'b00, k: 1'b0, word: 32'h0000_0000, nsym: 1,
                syms: {10'b1001110100, 30'b0}, invs: 4'b0000};
    vecs[1] = '{ds: 2'b00, k: 1'b1, word: 32'h0000_00BC, nsym: 1,
                syms: {10'b0011111010, 30'b0}, invs: 4'b0000};
    vecs[2] = '{ds: 2'b00, k: 1'b1, word: 32'h0000_0000, nsym: 1,
                syms: {10'b0110001011, 30'b0}, invs: 4'b1000};
    vecs[3] = '{ds: 2'b01, k: 1'b0, word: 32'h0000_ABCD, nsym: 2,
                syms: {10'b1011000110, 10'b1101001010, 20'b0}, invs: 4'b0000};
    vecs[4] = '{ds: 2'b10, k: 1'b0, word: 32'h0123_456F, nsym: 4,
                syms: {10'b1010001100, 10'b1010010101, 10'b1100011001, 10'b0111010100},
                invs: 4'b0000};
    vecs[5] = '{ds: 2'b11, k: 1'b0, word: 32'h0000_00F1, nsym: 1,
                syms: {10'b1000110111, 30'b0}, invs: 4'b0000};
    vecs[6] = '{ds: 2'b00, k: 1'b1, word: 32'h0000_00F7, nsym: 1,
                syms: {10'b0001010111, 30'b0}, invs: 4'b0000};
    vecs[7] = '{ds: 2'b00, k: 1'b1, word: 32'h0000_001C, nsym: 1,
                syms: {10'b1100001011, 30'b0}, invs: 4'b0000};
    vecs[8] = '{ds: 2'b01, k: 1'b1, word: 32'h0000_1CBC, nsym: 2,
                syms: {10'b1100000101, 10'b0011110100, 20'b0}, invs: 4'b0000};

    rst = 1'b0; enb = 1'b1; TxElecIdle = 1'b0;
    K = 1'b0; dataS = 2'b00; dataIn = '0; dataIn16 = '0; dataIn32 = '0;
    p1 = 1'b0; p2 = 1'b0; ds_prev = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 16; i++) begin
      scramble_data();
      r = $urandom;
      enb = r[0];
      TxElecIdle = r[1];
      @(negedge clk);
      chk($sformatf("rst%0d serialOut", i), serialOut, 1'b0);
      chk($sformatf("rst%0d dataSync", i), dataSync, 1'b0);
      chk($sformatf("rst%0d invalid_value", i), invalid_value, 1'b0);
    end
    enb = 1'b1;
    TxElecIdle = 1'b0;

    // Table: back-to-back words, data scrambled mid-word
    apply_vec(vecs[0]);
    rst = 1'b1;
    step(1'b0, 1'b0, "tbl capture");
    scramble_data();
    for (int v = 0; v < 9; v++) begin
      for (int s = 0; s < vecs[v].nsym; s++) begin
        sym = vecs[v].syms[39 - 10*s -: 10];
        for (int b = 0; b < 10; b++) begin
          step(sym[9 - b], vecs[v].invs[3 - s], $sformatf("v%0d s%0d b%0d", v, s, b));
          if ((s == vecs[v].nsym - 1) && (b == 8)) begin
            if (v < 8) apply_vec(vecs[v + 1]);
          end else begin
            scramble_data();
          end
        end
      end
    end

    // enb low mid-symbol freezes everything and resumes on the same bit
    do_reset();
    dataS = 2'b00; K = 1'b0; dataIn = 8'h00;
    rst = 1'b1;
    step(1'b0, 1'b0, "enb capture");
    send_bits(10'b1001110100, 0, 3, 1'b0, "enb pre");
    enb = 1'b0;
    for (int i = 0; i < 4; i++) freeze_step(1'b1, $sformatf("enb frozen%0d", i));
    enb = 1'b1;
    send_bits(10'b1001110100, 4, 9, 1'b0, "enb post");

    // TxElecIdle mid-symbol: zero from next cycle, RD held, fresh capture after
    do_reset();
    dataS = 2'b00; K = 1'b1; dataIn = 8'hBC;
    rst = 1'b1;
    step(1'b0, 1'b0, "idle capture");
    send_bits(10'b0011111010, 0, 8, 1'b0, "idle k28.5");
    K = 1'b0; dataIn = 8'h00;
    send_bits(10'b0011111010, 9, 9, 1'b0, "idle k28.5");
    send_bits(10'b0110001011, 0, 1, 1'b0, "idle d0.0+");
    TxElecIdle = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, $sformatf("idle hold%0d", i));
    TxElecIdle = 1'b0;
    step(1'b0, 1'b0, "idle recapture");
    send_bits(10'b0110001011, 0, 9, 1'b0, "idle resume");

    // Reset mid-word aborts it and restores RD-
    do_reset();
    dataS = 2'b00; K = 1'b1; dataIn = 8'hBC;
    rst = 1'b1;
    step(1'b0, 1'b0, "abort capture");
    send_bits(10'b0011111010, 0, 8, 1'b0, "abort k28.5");
    K = 1'b0; dataIn = 8'h00;
    send_bits(10'b0011111010, 9, 9, 1'b0, "abort k28.5");
    send_bits(10'b0110001011, 0, 2, 1'b0, "abort d0.0+");
    rst = 1'b0;
    #1;
    chk("abort async serialOut", serialOut, 1'b0);
    chk("abort async dataSync", dataSync, 1'b0);
    chk("abort async invalid_value", invalid_value, 1'b0);
    @(negedge clk);
    p1 = 1'b0; p2 = 1'b0; ds_prev = 1'b0;
    rst = 1'b1;
    step(1'b0, 1'b0, "abort recapture");
    send_bits(10'b1001110100, 0, 9, 1'b0, "abort fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/transmisor_sincronizador.md
TRANSMISOR_SINCRONIZADOR -- requirements
Module: transmisor_sincronizador

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port enb, input, 1 bit: enable; low freezes all registers.
REQ-004 SHALL have port K, input, 1 bit: control-symbol flag, applied to every byte of the current word.
REQ-005 SHALL have port dataIn, input, 8 bits: byte-mode word.
REQ-006 SHALL have port dataIn16, input, 16 bits: 2-byte-mode word.
REQ-007 SHALL have port dataIn32, input, 32 bits: 4-byte-mode word.
REQ-008 SHALL have port dataS, input, 2 bits: width select (00=8, 01=16, 10=32, 11=treated as 8).
REQ-009 SHALL have port TxElecIdle, input, 1 bit: electrical idle request.
REQ-010 SHALL have port serialOut, output, 1 bit: 8b/10b serial stream.
REQ-011 SHALL have port dataSync, output, 1 bit: serialOut passed through a 2-flop synchronizer.
REQ-012 SHALL have port invalid_value, output, 1 bit: K=1 with a byte that is not a legal control code.

Function
- REQ-013 SHALL capture dataS, K and the selected word at a word boundary: the first enabled edge after reset release, then every 10*N enabled cycles (N = 1/2/4 bytes of the captured mode).
- REQ-014 SHALL ignore dataS and data changes mid-word; a new width takes effect only at the next word boundary.
- REQ-015 SHALL send bytes least-significant first: 16-bit as [7:0],[15:8]; 32-bit as [7:0]..[31:24].
- REQ-016 SHALL encode each byte with standard 8b/10b (5b/6b + 3b/4b) and a running disparity (RD) updated after each symbol.
- REQ-017 SHALL, when K=1, emit control codes K28.0–K28.7, K23.7, K27.7, K29.7, K30.7.
- REQ-018 SHALL, for any other byte with K=1, encode the byte as data (Dx.y) and raise invalid_value for that symbol's 10 cycles.
- REQ-019 SHALL serialize each 10-bit symbol bit 'a' first through bit 'j', one bit per enabled cycle; the first bit appears on serialOut one cycle after capture.
- REQ-020 SHALL produce symbols back-to-back with no gap cycles.
- REQ-021 SHALL, when TxElecIdle=1, drive serialOut=0, reset the bit/byte counters, and hold RD.
- REQ-022 SHALL, on TxElecIdle falling, resume with a fresh word capture on the next enabled edge.
- REQ-023 SHALL, when enb=0, freeze all registers (counters, RD, shift register, synchronizer); outputs hold.
- REQ-024 SHALL make dataSync equal serialOut delayed by exactly 2 clk cycles when enabled.

Reset
- REQ-025 SHALL, while rst=0, force serialOut=0, dataSync=0, invalid_value=0, both synchronizer flops=0, counters=0, RD=negative.
- REQ-026 SHALL, when reset asserts mid-word, abort the word; no partial symbol resumes after release.

Structure
- REQ-027 SHALL place in a shared package: 5b/6b and 3b/4b code tables, the legal K-code list, dataS mode constants and the symbol length (10).
- REQ-028 SHALL implement the combinational byte+K+RD -> 10-bit symbol, new RD, and invalid flag in one sub-module, encoder_8b10b; serializer, word sequencer and 2-flop synchronizer stay in the top.

Verification
- REQ-029 SHALL check reset: rst=0 with random inputs -> serialOut=0, dataSync=0, invalid_value=0 throughout.
- REQ-030 SHALL check byte mode D0.0: dataS=00, K=0, dataIn=8'h00, RD- -> serialOut 1,0,0,1,1,1,0,1,0,0 with RD staying negative; dataSync shows the same bits 2 cycles later.
- REQ-031 SHALL check K28.5: K=1, dataIn=8'hBC, RD- -> bits 0,0,1,1,1,1,1,0,1,0, RD becomes positive, invalid_value=0.
- REQ-032 SHALL check an illegal K: K=1, dataIn=8'h00 -> invalid_value=1 for 10 cycles, D0.0 encoding sent.
- REQ-033 SHALL check 16-bit mode: dataS=01, dataIn16=16'hABCD -> symbols D13.6 (CD) then D11.5 (AB), 20 cycles; then dataS=10, dataIn32=32'h0123456F -> 4 symbols (6F,45,23,01) over 40 cycles.
- REQ-034 SHALL check enb and TxElecIdle: enb=0 mid-symbol -> serialOut and counters frozen, and resume on the same bit; TxElecIdle=1 -> serialOut=0 from the next cycle.
